lfsr_counter_tc: RTL

Parametrised loadable XNOR Fibonacci LFSR counter. It succeeds the fixed 4-bit loadable LFSR counter and adds:
- generic width and feedback polynomial
- up/down stepping through the sequence
- programmable terminal-count compare with free-run or one-shot mode
- lock-up state detection

It is used as a cheap pseudo-random sequence counter and timeout generator inside the counter subsystem.

---
 rtl/lfsr_counter_tc.sv | 97 +++++++++
 1 files changed

// File: rtl/lfsr_counter_tc.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_counter_tc
// Purpose  : Loadable XNOR Fibonacci LFSR counter with up/down stepping,
//            terminal-count compare (free-run or one-shot) and lock-up
//            detection. Define LFSR_LOCK_RECOVER_EN to have a step out of the
//            all-ones lock-up state jump to zero.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_counter_tc #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] POLY      = 8'hB8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_n,
    input  logic             cen,
    input  logic             up_dn,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] tc_val,
    input  logic             oneshot,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             lock_err
);

    localparam logic [WIDTH-1:0] c_ALL_ONES = '1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_done;
    logic             r_lock_err;

    logic             w_fwd_fb;
    logic             w_bwd_msb;
    logic [WIDTH-1:0] w_fwd;
    logic [WIDTH-1:0] w_bwd;
    logic [WIDTH-1:0] w_next;
    logic             w_stuck;
    logic             w_step;
    logic             w_hit;

    // The backward bit recovers the MSB shifted out by the forward step:
    // POLY[WIDTH-1] is always a tap, so it can be solved from the feedback bit.
    assign w_fwd_fb  = ~^(r_count & POLY);
    assign w_bwd_msb = ~r_count[0] ^ (^(r_count[WIDTH-1:1] & POLY[WIDTH-2:0]));
    assign w_fwd     = {r_count[WIDTH-2:0], w_fwd_fb};
    assign w_bwd     = {w_bwd_msb, r_count[WIDTH-1:1]};
    assign w_stuck   = (r_count == c_ALL_ONES);
    assign w_step    = cen & ~(oneshot & r_done);

`ifdef LFSR_LOCK_RECOVER_EN
    assign w_next = w_stuck ? '0 : (up_dn ? w_fwd : w_bwd);
`else
    assign w_next = up_dn ? w_fwd : w_bwd;
`endif

    assign w_hit = (w_next == tc_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= RESET_VAL;
            r_tc       <= 1'b0;
            r_done     <= 1'b0;
            r_lock_err <= 1'b0;
        end else if (!load_n) begin
            r_count    <= data;
            r_tc       <= 1'b0;
            r_done     <= 1'b0;
            r_lock_err <= (data == c_ALL_ONES);
        end else if (w_step) begin
            r_count <= w_next;
            r_tc    <= w_hit;
            r_done  <= oneshot & w_hit;
`ifdef LFSR_LOCK_RECOVER_EN
            if (w_stuck) begin
                r_lock_err <= 1'b0;
            end
`endif
        end else begin
            r_tc <= 1'b0;
            // Leaving one-shot mode releases a stopped run.
            if (!oneshot) begin
                r_done <= 1'b0;
            end
        end
    end

    assign count    = r_count;
    assign tc       = r_tc;
    assign done     = r_done;
    assign lock_err = r_lock_err;

endmodule
`default_nettype wire
